// File: rtl/scan_pkg.sv
// Shared types and constants for the LED matrix scan sequencer.
// SCAN_BLANKING_EN adds the BLANK state between column drives.
package scan_pkg;
    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int FRAME_W  = 35;
    localparam logic [2:0] COL_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE
`ifdef SCAN_BLANKING_EN
        , BLANK
`endif
    } state_t;

    // Row slice of one column; only called with col 0..4.
    function automatic logic [NUM_ROWS-1:0] col_rows(input logic [FRAME_W-1:0] frame,
                                                     input logic [2:0] col);
        return frame[int'(col)*NUM_ROWS +: NUM_ROWS];
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler that pulses tc on its last count of LEN; clear holds it at 0.
module scan_tick_gen #(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tc
);
    localparam int W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [W-1:0] LAST = W'(LEN - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tc = !clear && (cnt == LAST);
endmodule

// File: rtl/matrix_scan_sequencer.sv
// Column scan sequencer for a 5x7 LED matrix with a double-buffered frame.
// Define SCAN_BLANKING_EN to insert BLANK_CYCLES dark cycles after every column.
module matrix_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_load,
    output logic [2:0]         counter,
    output logic [6:0]         rows,
    output logic               frame_done
);
    state_t             state;
    logic [FRAME_W-1:0] active, pending, next_active, next_pending;
    logic               pending_valid, next_pv;
    logic [2:0]         col_idx, next_col;
    logic               drive_tc, col_step, wrap;

    scan_tick_gen #(.LEN(DIV)) u_drive_tick (
        .clk   (clk),
        .reset (reset),
        .clear (!enable || state != DRIVE),
        .tc    (drive_tc)
    );

`ifdef SCAN_BLANKING_EN
    logic blank_tc;

    scan_tick_gen #(.LEN(BLANK_CYCLES)) u_blank_tick (
        .clk   (clk),
        .reset (reset),
        .clear (!enable || state != BLANK),
        .tc    (blank_tc)
    );

    assign col_step = enable && (state == BLANK) && blank_tc;
`else
    assign col_step = enable && (state == DRIVE) && drive_tc;
`endif

    assign next_col = (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
    assign wrap     = col_step && (col_idx == 3'd4);

    // A load landing on the wrap edge bypasses pending and shows at once.
    always_comb begin
        next_active  = active;
        next_pending = pending;
        next_pv      = pending_valid;
        if (frame_load) begin
            next_pending = frame_in;
            next_pv      = 1'b1;
        end
        if (wrap) begin
            if (frame_load) begin
                next_active = frame_in;
                next_pv     = 1'b0;
            end else if (pending_valid) begin
                next_active = pending;
                next_pv     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= COL_NONE;
            rows          <= '0;
            frame_done    <= 1'b0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            col_idx       <= 3'd0;
        end else begin
            active        <= next_active;
            pending       <= next_pending;
            pending_valid <= next_pv;
            frame_done    <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                counter <= COL_NONE;
                rows    <= '0;
                col_idx <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= DRIVE;
                        col_idx <= 3'd0;
                        counter <= 3'd0;
                        rows    <= col_rows(active, 3'd0);
                    end
                    DRIVE: begin
`ifdef SCAN_BLANKING_EN
                        if (drive_tc) begin
                            state   <= BLANK;
                            counter <= COL_NONE;
                            rows    <= '0;
                        end
`else
                        if (col_step) begin
                            col_idx    <= next_col;
                            counter    <= next_col;
                            rows       <= col_rows(next_active, next_col);
                            frame_done <= wrap;
                        end
`endif
                    end
`ifdef SCAN_BLANKING_EN
                    BLANK: begin
                        if (col_step) begin
                            state      <= DRIVE;
                            col_idx    <= next_col;
                            counter    <= next_col;
                            rows       <= col_rows(next_active, next_col);
                            frame_done <= wrap;
                        end
                    end
`endif
                    default: begin
                        state   <= IDLE;
                        counter <= COL_NONE;
                        rows    <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// Directed bench for matrix_scan_sequencer (DIV=4); column timing follows SCAN_BLANKING_EN.
module tb_matrix_scan_sequencer;
    localparam int DIV = 4;
`ifdef SCAN_BLANKING_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int CP = DIV + BL;
    localparam int FP = 5 * CP;

    localparam logic [34:0] ONES = 35'h7_FFFF_FFFF;
    localparam logic [34:0] FA   = 35'h1_2345_6789;
    localparam logic [34:0] FB   = 35'h5_A5A5_A5A5;
    localparam logic [34:0] FC   = 35'h3_0F0F_0F0F;
    localparam logic [34:0] FD   = 35'h2_4924_9249;

    logic        clk = 1'b0;
    logic        reset, enable, frame_load;
    logic [34:0] frame_in;
    logic [2:0]  counter;
    logic [6:0]  rows;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    matrix_scan_sequencer #(.DIV(DIV), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_in   (frame_in),
        .frame_load (frame_load),
        .counter    (counter),
        .rows       (rows),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] c, input logic [6:0] r, input logic fd);
        chk({tag, ".counter"}, 35'(counter), 35'(c));
        chk({tag, ".rows"}, 35'(rows), 35'(r));
        chk({tag, ".frame_done"}, 35'(frame_done), 35'(fd));
    endtask

    // Entered on the first column-0 drive cycle; checks n cycles of the scan of 'shown'.
    task automatic run_frame(input string tag, input logic [34:0] shown, input logic fd0,
                             input int n, input int la, input logic [34:0] lav,
                             input int lb, input logic [34:0] lbv);
        for (int i = 0; i < n; i++) begin
            int col;
            int p;
            logic [2:0] ec;
            logic [6:0] er;
            col = i / CP;
            p   = i % CP;
            if (p < DIV) begin
                ec = 3'(col);
                er = shown[col*7 +: 7];
            end else begin
                ec = 3'd7;
                er = 7'd0;
            end
            chk_out($sformatf("%s[%0d]", tag, i), ec, er, (i == 0) ? fd0 : 1'b0);
            if (i == la) begin
                frame_in = lav; frame_load = 1'b1;
            end else if (i == lb) begin
                frame_in = lbv; frame_load = 1'b1;
            end else begin
                frame_load = 1'b0;
            end
            tick();
        end
        frame_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; frame_load = 1'b0; frame_in = '0;
        tick(); tick();
        chk_out("reset", 3'd7, 7'd0, 1'b0);

        // Load while idle: goes to pending, first frame still shows the reset buffer.
        reset = 1'b0; frame_in = 35'h1; frame_load = 1'b1;
        tick();
        frame_load = 1'b0;
        chk_out("idle_load", 3'd7, 7'd0, 1'b0);
        enable = 1'b1;
        tick();
        run_frame("f1", 35'h0, 1'b0, FP, -1, '0, -1, '0);
        // Swapped-in frame; all-ones load mid column 2 must wait for the next wrap.
        run_frame("f2", 35'h1, 1'b1, FP, 2*CP + 1, ONES, -1, '0);
        // A then B within one frame: only B is shown next.
        run_frame("f3", ONES, 1'b1, FP, CP, FA, 3*CP, FB);
        // C loaded on the wrap edge itself.
        run_frame("f4", FB, 1'b1, FP, FP - 1, FC, -1, '0);
        run_frame("f5", FC, 1'b1, 3*CP + 1, -1, '0, -1, '0);

        // Disable mid column 3.
        enable = 1'b0;
        tick();
        chk_out("disable", 3'd7, 7'd0, 1'b0);
        tick();
        chk_out("disable_hold", 3'd7, 7'd0, 1'b0);
        enable = 1'b1;
        tick();
        run_frame("reen", FC, 1'b0, 2*CP + 1, CP, FD, -1, '0);

        // Reset during column 2 discards the pending D and the active C.
        reset = 1'b1;
        tick();
        chk_out("mid_reset", 3'd7, 7'd0, 1'b0);
        reset = 1'b0;
        tick();
        run_frame("post_reset", 35'h0, 1'b0, FP, -1, '0, -1, '0);
        run_frame("post_reset_wrap", 35'h0, 1'b1, CP, -1, '0, -1, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
